mux_dff_pipe: RTL and testbench

- Parametrised successor to the 2-input mux-and-register cell in the PE datapath.
- Selects one of N_IN operand channels and carries the selected word through a DEPTH-stage elastic pipeline with valid/ready flow control.
- Each stage can hold, advance or collapse a bubble independently, so the PE array can stall without losing operands.
- Adds an out-of-range-select error tag and a synchronous flush.

---
 rtl/mux_dff_pipe.sv | 110 +++++++++++
 tb/tb_mux_dff_pipe.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_dff_pipe.sv
// mux_dff_pipe: N_IN-way operand select feeding a DEPTH-stage
// elastic valid/ready pipeline with error tag and flush.
module mux_dff_pipe #(
  parameter int data_width = 24,
  parameter int N_IN       = 4,
  parameter int DEPTH      = 2,
  localparam int SEL_W     = (N_IN > 2) ? $clog2(N_IN) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_IN*data_width-1:0] in_data,
  input  logic [SEL_W-1:0]           sel,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       flush,
  output logic [data_width-1:0]      out_data,
  output logic [SEL_W-1:0]           out_sel,
  output logic                       out_err,
  output logic                       out_valid,
  input  logic                       out_ready
);

  logic [DEPTH-1:0]                 v_q;
  logic [DEPTH-1:0]                 v_d;
  logic [DEPTH-1:0][data_width-1:0] d_q;
  logic [DEPTH-1:0][data_width-1:0] d_d;
  logic [DEPTH-1:0][SEL_W-1:0]      s_q;
  logic [DEPTH-1:0][SEL_W-1:0]      s_d;
  logic [DEPTH-1:0]                 e_q;
  logic [DEPTH-1:0]                 e_d;

  logic [DEPTH-1:0]      adv;
  logic [data_width-1:0] mux_data;
  logic                  sel_err;
  logic                  accept;

  // Channel select; out-of-range indices yield zero data.
  always_comb begin
    mux_data = '0;
    sel_err  = (int'(sel) >= N_IN);
    for (int k = 0; k < N_IN; k++) begin
      if (int'(sel) == k) begin
        mux_data = in_data[k*data_width +: data_width];
      end
    end
  end

  // Advance chain: a stage moves if the next one is empty or moving.
  always_comb begin
    adv = '0;
    adv[DEPTH-1] = v_q[DEPTH-1] & out_ready;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      adv[i] = v_q[i] & (~v_q[i+1] | adv[i+1]);
    end
  end

  assign in_ready = ~rst & ~flush & (~v_q[0] | adv[0]);
  assign accept   = in_valid & in_ready;

  // Stage next-state: drain, reload from upstream, then flush.
  always_comb begin
    v_d = v_q;
    d_d = d_q;
    s_d = s_q;
    e_d = e_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (adv[i]) begin
        v_d[i] = 1'b0;
      end
    end
    if (accept) begin
      v_d[0] = 1'b1;
      d_d[0] = mux_data;
      s_d[0] = sel;
      e_d[0] = sel_err;
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (adv[i-1]) begin
        v_d[i] = 1'b1;
        d_d[i] = d_q[i-1];
        s_d[i] = s_q[i-1];
        e_d[i] = e_q[i-1];
      end
    end
    if (flush) begin
      v_d = '0;
    end
  end

  // Stage registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= '0;
      d_q <= '0;
      s_q <= '0;
      e_q <= '0;
    end else begin
      v_q <= v_d;
      d_q <= d_d;
      s_q <= s_d;
      e_q <= e_d;
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = d_q[DEPTH-1];
  assign out_sel   = s_q[DEPTH-1];
  assign out_err   = e_q[DEPTH-1];

endmodule

// File: tb/tb_mux_dff_pipe.sv
// tb_mux_dff_pipe: directed and randomized checks of mux_dff_pipe
// against a queue-based beat model.
module tb_mux_dff_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [26:0] beat(input logic [95:0] dat,
                                       input int n,
                                       input logic [1:0] s);
    logic [23:0] w;
    w = '0;
    if (int'(s) < n) w = dat[int'(s)*24 +: 24];
    return {(int'(s) >= n), s, w};
  endfunction

  logic [95:0] id0, id2, tmp;
  logic [71:0] id1;
  logic [1:0]  s0, s1, s2, os0, os1, os2;
  logic        iv0, iv1, iv2, ir0, ir1, ir2;
  logic        fl0, fl1, fl2, or0, or1, or2;
  logic        oe0, oe1, oe2, ov0, ov1, ov2;
  logic [23:0] od0, od1, od2;

  mux_dff_pipe #(.data_width(24), .N_IN(4), .DEPTH(2)) u0 (
    .clk(clk), .rst(rst), .in_data(id0), .sel(s0),
    .in_valid(iv0), .in_ready(ir0), .flush(fl0),
    .out_data(od0), .out_sel(os0), .out_err(oe0),
    .out_valid(ov0), .out_ready(or0));

  mux_dff_pipe #(.data_width(24), .N_IN(3), .DEPTH(1)) u1 (
    .clk(clk), .rst(rst), .in_data(id1), .sel(s1),
    .in_valid(iv1), .in_ready(ir1), .flush(fl1),
    .out_data(od1), .out_sel(os1), .out_err(oe1),
    .out_valid(ov1), .out_ready(or1));

  mux_dff_pipe #(.data_width(24), .N_IN(4), .DEPTH(4)) u2 (
    .clk(clk), .rst(rst), .in_data(id2), .sel(s2),
    .in_valid(iv2), .in_ready(ir2), .flush(fl2),
    .out_data(od2), .out_sel(os2), .out_err(oe2),
    .out_valid(ov2), .out_ready(or2));

  logic [26:0] q1[$];
  logic [26:0] q2[$];
  logic [26:0] e;
  int acc1, acc2, cyc;
  logic xr1, xr2;

  initial begin
    rst = 1'b1;
    {iv0, iv1, iv2, fl0, fl1, fl2} = '0;
    {or0, or1, or2} = '0;
    {s0, s1, s2} = '0;
    id0 = {24'h44, 24'h33, 24'h22, 24'h11};
    id1 = {24'hC3, 24'hB2, 24'hA1};
    id2 = '0;

    // reset and idle
    @(negedge clk); #1;
    chk("rst_rdy", ir0, 0);
    chk("rst_v", ov0, 0);
    chk("rst_d", od0, 0);
    chk("rst_se", {os0, oe0}, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("idle_rdy", ir0, 1);
    chk("idle_v", ov0, 0);

    // streaming select pattern
    or0 = 1'b1;
    @(negedge clk); iv0 = 1'b1; s0 = 2'd2;
    @(negedge clk); s0 = 2'd0; #1;
    chk("st_lat", ov0, 0);
    @(negedge clk); s0 = 2'd3; #1;
    chk("st_b0", {ov0, oe0, od0}, {2'b10, 24'h33});
    @(negedge clk); s0 = 2'd1; #1;
    chk("st_b1", {ov0, oe0, od0}, {2'b10, 24'h11});
    @(negedge clk); iv0 = 1'b0; #1;
    chk("st_b2", {ov0, oe0, od0}, {2'b10, 24'h44});
    @(negedge clk); #1;
    chk("st_b3", {ov0, oe0, od0}, {2'b10, 24'h22});
    @(negedge clk); #1;
    chk("st_end", ov0, 0);

    // fill, stall, single-cycle release
    or0 = 1'b0;
    @(negedge clk); iv0 = 1'b1; s0 = 2'd0; #1;
    chk("fl_r0", ir0, 1);
    @(negedge clk); s0 = 2'd1; #1;
    chk("fl_r1", ir0, 1);
    @(negedge clk); s0 = 2'd2; #1;
    chk("fl_full", ir0, 0);
    chk("fl_head", {ov0, od0}, {1'b1, 24'h11});
    @(negedge clk); #1;
    chk("fl_hold", {ir0, ov0, od0}, {2'b01, 24'h11});
    or0 = 1'b1; #1;
    chk("fl_rel", ir0, 1);
    @(negedge clk); iv0 = 1'b0; #1;
    chk("fl_b1", {ov0, od0}, {1'b1, 24'h22});
    @(negedge clk); #1;
    chk("fl_b2", {ov0, od0}, {1'b1, 24'h33});
    @(negedge clk); #1;
    chk("fl_end", ov0, 0);

    // out-of-range select on N_IN=3
    or1 = 1'b1;
    @(negedge clk); iv1 = 1'b1; s1 = 2'd3;
    @(negedge clk); s1 = 2'd1; #1;
    chk("oor_err", {ov1, oe1, os1, od1}, {4'b1111, 24'h0});
    @(negedge clk); iv1 = 1'b0; #1;
    chk("oor_ok", {ov1, oe1, os1, od1}, {4'b1001, 24'hB2});
    @(negedge clk); #1;
    chk("oor_end", ov1, 0);

    // flush with two beats in flight
    or0 = 1'b0;
    @(negedge clk); iv0 = 1'b1; s0 = 2'd0;
    @(negedge clk); s0 = 2'd1;
    @(negedge clk); fl0 = 1'b1; s0 = 2'd2; #1;
    chk("fsh_rdy", ir0, 0);
    @(negedge clk); fl0 = 1'b0; s0 = 2'd3; or0 = 1'b1; #1;
    chk("fsh_gone", ov0, 0);
    chk("fsh_rdy1", ir0, 1);
    @(negedge clk); iv0 = 1'b0; #1;
    chk("fsh_lat", ov0, 0);
    @(negedge clk); #1;
    chk("fsh_new", {ov0, os0, od0}, {3'b111, 24'h44});
    @(negedge clk); #1;
    chk("fsh_end", ov0, 0);

    // randomized traffic, DEPTH=1 and DEPTH=4, reset pulse mid-run
    acc1 = 0;
    acc2 = 0;
    cyc  = 0;
    while ((acc1 < 1000 || acc2 < 1000 ||
            q1.size() != 0 || q2.size() != 0) && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      rst = (cyc == 400);
      if (rst) begin
        q1.delete();
        q2.delete();
      end
      iv1 = (acc1 < 1000) && ($urandom_range(0, 1) == 1);
      iv2 = (acc2 < 1000) && ($urandom_range(0, 1) == 1);
      or1 = ($urandom_range(0, 1) == 1);
      or2 = ($urandom_range(0, 1) == 1);
      s1 = 2'($urandom_range(0, 3));
      s2 = 2'($urandom_range(0, 3));
      tmp = {$urandom(), $urandom(), $urandom()};
      id1 = tmp[71:0];
      id2 = {$urandom(), $urandom(), $urandom()};
      #1;
      xr1 = !rst && (q1.size() < 1 || or1);
      xr2 = !rst && (q2.size() < 4 || or2);
      chk("r_rdy1", ir1, xr1);
      chk("r_rdy2", ir2, xr2);
      if (rst) begin
        chk("r_rst1", ov1, 0);
        chk("r_rst2", ov2, 0);
      end
      if (ov1 && or1) begin
        chk("r_have1", q1.size() > 0, 1);
        if (q1.size() > 0) begin
          e = q1.pop_front();
          chk("r_dat1", {oe1, os1, od1}, e);
        end
      end
      if (ov2 && or2) begin
        chk("r_have2", q2.size() > 0, 1);
        if (q2.size() > 0) begin
          e = q2.pop_front();
          chk("r_dat2", {oe2, os2, od2}, e);
        end
      end
      if (iv1 && xr1) begin
        q1.push_back(beat({24'h0, id1}, 3, s1));
        acc1++;
      end
      if (iv2 && xr2) begin
        q2.push_back(beat(id2, 4, s2));
        acc2++;
      end
    end
    chk("r_acc1", acc1, 1000);
    chk("r_acc2", acc2, 1000);
    chk("r_drain1", q1.size(), 0);
    chk("r_drain2", q2.size(), 0);
    @(negedge clk); {or1, or2} = 2'b11; #1;
    chk("r_empty", {ov1, ov2}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
